// File: rtl/prco_encoder.sv
// PRCO instruction emitter: packs field-level requests into 16-bit words, queues
// them in a small FIFO and writes them sequentially into program memory.
module prco_encoder #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic [ADDR_W-1:0] i_base,
  input  logic              i_valid,
  output logic              q_ready,
  input  logic [1:0]        i_fmt,
  input  logic [4:0]        i_op,
  input  logic [2:0]        i_rd,
  input  logic [2:0]        i_ra,
  input  logic [7:0]        i_imm,
  output logic              q_mem_we,
  output logic [ADDR_W-1:0] q_mem_addr,
  output logic [15:0]       q_mem_data,
  input  logic              i_mem_busy,
  output logic [ADDR_W:0]   q_count,
  output logic              q_full,
  output logic [1:0]        q_err,
  output logic              q_done,
  output logic [1:0]        q_state
);

  // Handshake: a request transfers on a posedge where i_valid & q_ready are both
  // high; the requester holds its fields stable until then. A memory write
  // completes on a posedge where q_mem_we & !i_mem_busy.

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]    PTR_ONE  = 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_W:0]   CNT_ONE  = 1;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_FMT     = 2'd1;
  localparam logic [1:0] ERR_RANGE   = 2'd2;
  localparam logic [1:0] ERR_OVERRUN = 2'd3;

  state_t state, state_next;

  logic [15:0]    fifo_mem [DEPTH];
  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] rd_ptr;
  logic           fifo_empty;
  logic           fifo_full;

  logic [15:0] packed_word;
  logic [1:0]  req_err;
  logic        accept;
  logic        enq;
  logic        wr_done;
  logic        discard;
  logic        deq;
  logic        drain_phase;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  // Field packing and legality; an errored request is accepted but never queued.
  always_comb begin
    packed_word = 16'h0000;
    req_err     = ERR_NONE;
    case (i_fmt)
      2'd0: packed_word = {i_op, i_rd, i_ra, 5'b00000};
      2'd1: packed_word = {i_op, i_rd, i_imm};
      2'd2: begin
        packed_word = {i_op, i_rd, i_ra, i_imm[4:0]};
        if (!((i_imm[7:4] == 4'h0) || (i_imm[7:4] == 4'hF))) begin
          req_err = ERR_RANGE;
        end
      end
      default: req_err = ERR_FMT;
    endcase
  end

  assign accept  = i_valid & q_ready;
  assign enq     = accept & (req_err == ERR_NONE);
  assign wr_done = q_mem_we & ~i_mem_busy;
  assign discard = q_full & ~fifo_empty;
  assign deq     = wr_done | discard;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (i_start) begin
      state_next = ST_RUN;
    end else begin
      case (state)
        ST_RUN:   if (i_stop) state_next = ST_FLUSH;
        ST_FLUSH: if (fifo_empty) state_next = ST_DONE;
        default:  state_next = state;
      endcase
    end
  end

  always_comb begin
    drain_phase = (state == ST_RUN) || (state == ST_FLUSH);
    q_ready     = (state == ST_RUN) & ~fifo_full & ~q_full;
    q_done      = (state == ST_DONE);
    q_mem_we    = ~fifo_empty & drain_phase & ~q_full;
  end

  assign q_state    = state;
  assign q_mem_data = q_mem_we ? fifo_mem[rd_ptr[PTR_W-1:0]] : 16'h0000;

  // Start wins over everything else in the same cycle, including a completing write.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      q_mem_addr <= '0;
      q_count    <= '0;
      q_full     <= 1'b0;
      q_err      <= ERR_NONE;
    end else if (i_start) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      q_mem_addr <= i_base;
      q_count    <= '0;
      q_full     <= 1'b0;
      q_err      <= ERR_NONE;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (deq) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (wr_done) begin
        q_count <= q_count + CNT_ONE;
        if (&q_mem_addr) begin
          q_full <= 1'b1;
        end else begin
          q_mem_addr <= q_mem_addr + ADDR_ONE;
        end
      end
      if (q_err == ERR_NONE) begin
        if (accept && (req_err != ERR_NONE)) begin
          q_err <= req_err;
        end else if (discard) begin
          q_err <= ERR_OVERRUN;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (enq) begin
      fifo_mem[wr_ptr[PTR_W-1:0]] <= packed_word;
    end
  end

endmodule
